// File: rtl/proc_pix_reader.sv
// proc_pix_reader: forecasts raster LEAD cycles ahead, reads packed pixel pairs from ZBT bank 1 and emits RGB888 aligned to hcount/vcount
module proc_pix_reader #(
  parameter int READ_LAT = 6,
  parameter int H_TOTAL  = 1056,
  parameter int V_TOTAL  = 806,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        enable,
  input  logic [35:0] read_data,
  output logic [18:0] read_addr,
  output logic [23:0] pixel,
  output logic        pixel_valid,
  output logic [7:0]  frame_count
);
  localparam int LEAD = READ_LAT + 2;
  typedef enum logic [1:0] {WAIT_SOF, RUN, MUTE} state_t;
  typedef struct packed {
    logic v;
    logic odd;
    logic vis;
    logic run;
  } tag_t;
  state_t state;
  tag_t tag [READ_LAT+1];
  logic wrap, sof, vis, run_now, show;
  logic [10:0] hf;
  logic [9:0] vf;
  logic [17:0] half;
  always_comb begin
    wrap = hcount >= 11'(H_TOTAL - LEAD);
    hf = wrap ? hcount - 11'(H_TOTAL - LEAD) : hcount + 11'(LEAD);
    vf = wrap ? (vcount == 10'(V_TOTAL - 1) ? 10'd0 : vcount + 10'd1) : vcount;
    sof = hf == 11'd0 && vf == 10'd0;
    vis = hf < 11'(H_ACTIVE) && vf < 10'(V_ACTIVE);
    // a frame's mode is decided by the state it will have at its own SOF
    run_now = sof ? enable : state == RUN;
    half = tag[READ_LAT].odd ? read_data[17:0] : read_data[35:18];
    show = tag[READ_LAT].v && tag[READ_LAT].vis && tag[READ_LAT].run;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      read_addr <= '0;
      pixel <= '0;
      pixel_valid <= 1'b0;
      frame_count <= '0;
      state <= WAIT_SOF;
      for (int i = 0; i <= READ_LAT; i++) tag[i] <= '0;
    end else begin
      read_addr <= {vf, hf[9:1]};
      tag[0] <= '{v: 1'b1, odd: hf[0], vis: vis, run: run_now};
      for (int i = 1; i <= READ_LAT; i++) tag[i] <= tag[i-1];
      pixel <= show ? {half[17:12], half[17:16], half[11:6], half[11:10], half[5:0], half[5:4]} : 24'd0;
      pixel_valid <= show;
      if (sof) begin
        state <= enable ? RUN : MUTE;
        if (enable) frame_count <= frame_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_proc_pix_reader.sv
// tb_proc_pix_reader: directed raster/ZBT stimulus with a latency-6 memory model
module tb_proc_pix_reader;
  logic clk = 1'b0;
  logic reset, enable;
  logic [10:0] hcount;
  logic [9:0] vcount;
  logic [35:0] read_data;
  logic [18:0] read_addr;
  logic [23:0] pixel;
  logic pixel_valid;
  logic [7:0] frame_count;
  logic [18:0] hist [6];
  int checks = 0, errors = 0;

  proc_pix_reader dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .enable(enable),
    .read_data(read_data), .read_addr(read_addr), .pixel(pixel),
    .pixel_valid(pixel_valid), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    hist[0] <= read_addr;
    for (int i = 1; i < 6; i++) hist[i] <= hist[i-1];
  end
  assign read_data = {hist[5][17:0], ~hist[5][17:0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", tag, got, exp, hcount, vcount);
    end
  endtask

  function automatic logic [23:0] e24(input logic [17:0] p);
    return {p[17:12], p[17:16], p[11:6], p[11:10], p[5:0], p[5:4]};
  endfunction

  task automatic set_pos(input int h, input int v);
    hcount = 11'(h);
    vcount = 10'(v);
  endtask

  // mode: 0 = no pixel check, 1 = expect black, 2 = expect frame data
  task automatic tick(input int mode);
    logic [10:0] ph, fh;
    logic [9:0] pv, fv;
    logic rw, vis;
    logic [17:0] a, hlf;
    ph = hcount;
    pv = vcount;
    rw = reset;
    @(posedge clk);
    #1;
    if (hcount == 11'd1055) begin
      hcount = 11'd0;
      vcount = vcount == 10'd805 ? 10'd0 : vcount + 10'd1;
    end else hcount = hcount + 11'd1;
    if (!rw) begin
      fh = ph >= 11'd1048 ? ph - 11'd1048 : ph + 11'd8;
      fv = ph >= 11'd1048 ? (pv == 10'd805 ? 10'd0 : pv + 10'd1) : pv;
      check("read_addr", 32'(read_addr), 32'({fv, fh[9:1]}));
    end
    if (mode == 1) begin
      check("black_valid", 32'(pixel_valid), 32'd0);
      check("black_pixel", 32'(pixel), 32'd0);
    end else if (mode == 2) begin
      a = {vcount[8:0], hcount[9:1]};
      hlf = hcount[0] ? ~a : a;
      vis = hcount < 11'd1024 && vcount < 10'd768;
      check("valid", 32'(pixel_valid), 32'(vis));
      check("pixel", 32'(pixel), vis ? 32'(e24(hlf)) : 32'd0);
    end
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) tick(mode);
  endtask

  task automatic frame(input bit show, input int exp_count);
    set_pos(1040, 805);
    run(8, 0);
    run(7, 1);
    run(25, show ? 2 : 1);
    check("frame_count", 32'(frame_count), 32'(exp_count));
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    set_pos(0, 0);
    run(3, 0);
    check("rst_addr", 32'(read_addr), 32'd0);
    check("rst_valid", 32'(pixel_valid), 32'd0);
    check("rst_pixel", 32'(pixel), 32'd0);
    check("rst_count", 32'(frame_count), 32'd0);
    set_pos(100, 5);
    reset = 1'b0;
    tick(1);
    check("addr_100_5", 32'(read_addr), 32'({10'd5, 9'd54}));
    set_pos(1050, 805);
    tick(1);
    check("addr_wrap", 32'(read_addr), 32'({10'd0, 9'd1}));
    set_pos(1047, 10);
    tick(1);
    check("addr_1047", 32'(read_addr), 32'({10'd10, 9'd15}));
    run(10, 1);
    frame(1'b1, 1);
    set_pos(200, 300);
    run(8, 0);
    run(10, 2);
    frame(1'b1, 2);
    frame(1'b1, 3);
    enable = 1'b0;
    set_pos(100, 10);
    run(8, 0);
    run(10, 2);
    frame(1'b0, 3);
    set_pos(300, 400);
    run(8, 0);
    run(6, 1);
    frame(1'b0, 3);
    enable = 1'b1;
    set_pos(300, 400);
    run(8, 0);
    run(6, 1);
    frame(1'b1, 4);
    set_pos(1018, 300);
    run(8, 0);
    run(14, 2);
    set_pos(500, 770);
    run(8, 0);
    run(4, 2);
    set_pos(1040, 10);
    run(8, 0);
    run(10, 2);
    set_pos(492, 300);
    run(8, 0);
    run(1, 2);
    reset = 1'b1;
    tick(0);
    reset = 1'b0;
    check("rst_mid_valid", 32'(pixel_valid), 32'd0);
    check("rst_mid_count", 32'(frame_count), 32'd0);
    run(12, 1);
    frame(1'b1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
